// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell with a registered borrow; the parallel result is held until the next operation.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_busy,
    output logic             o_d_bit,
    output logic             o_d_valid,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout,
    output logic             o_done
);

    // state | meaning
    // IDLE  | waiting for start
    // SHIFT | one operand bit per cycle through the subtractor cell
    // DONE  | single-cycle result strobe; a start here chains a new run
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_br_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    assign w_accept  = i_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_nxt  = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
    assign o_busy    = (r_state == SHIFT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = w_accept ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_br      <= 1'b0;
            r_cnt     <= '0;
            o_d_bit   <= 1'b0;
            o_d_valid <= 1'b0;
            o_diff    <= '0;
            o_bout    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_d_valid <= 1'b0;
            o_done    <= 1'b0;
            if (w_accept) begin
                r_a   <= i_a;
                r_b   <= i_b;
                r_br  <= i_bin;
                r_cnt <= '0;
            end
            if (r_state == SHIFT) begin
                r_a       <= r_a >> 1;
                r_b       <= r_b >> 1;
                r_res     <= w_res_nxt;
                r_br      <= w_br_nxt;
                r_cnt     <= r_cnt + 1'b1;
                o_d_bit   <= w_d;
                o_d_valid <= 1'b1;
                // The last bit has not reached r_res yet, so publish the shifted value.
                if (w_last) begin
                    o_diff <= w_res_nxt;
                    o_bout <= w_br_nxt;
                    o_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial N-bit subtractor: computes a − b − bin one bit per clock, LSB first, using a single registered full-subtractor cell and a registered borrow. It is the subtract counterpart of the team's registered full-adder datapath cell, for area-constrained arithmetic where one bit per cycle is acceptable. The block has a start/busy/done handshake and a serial difference stream, and holds the parallel result until the next operation completes.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  clock, rising-edge
- rstn  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend; sampled with accepted start
- b  input  WIDTH  subtrahend; sampled with accepted start
- bin  input  1  borrow-in; sampled with accepted start
- busy  output  1  high while bits are being processed
- d_bit  output  1  serial difference bit, valid when d_valid=1
- d_valid  output  1  one-cycle strobe per difference bit
- diff  output  WIDTH  parallel difference, (a − b − bin) mod 2^WIDTH
- bout  output  1  final borrow-out; 1 when a < b + bin (unsigned)
- done  output  1  one-cycle pulse when diff/bout update

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (async, any state, including mid-operation): state=IDLE; busy, d_bit, d_valid, done, bout = 0; diff = 0; internal shift registers, borrow and bit counter cleared. The in-flight operation is discarded.
- IDLE, start=1: capture a, b into shift registers. Set borrow=bin and bit counter=0, then go to SHIFT. With start=0, stay in IDLE.
- SHIFT, each cycle, with a0, b0 as the current LSBs and br as the borrow:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~a0 & br) | (b0 & br)
  - Shift both operand registers right by one.
  - Shift d into the MSB of the internal result register.
  - Drive d_bit=d and d_valid=1 (registered).
  - Increment the counter.
- SHIFT ends after the cycle that processes bit WIDTH−1, then goes to DONE. On that edge: diff ← internal result register, bout ← br_next, done=1.
- DONE lasts one cycle:
  - If start=1 in that cycle, the new operands are accepted and the next state is SHIFT.
  - Otherwise the next state is IDLE.
- start while busy=1 (SHIFT) is ignored completely; operands are not resampled.
- diff and bout change only on the edge that raises done; otherwise they hold the last result. After reset they hold 0.
- Arithmetic is unsigned modulo 2^WIDTH; no overflow flag. The counter is $clog2(WIDTH)+1 bits wide, so it never wraps during an operation.

## Timing
- Edge E0 samples start=1 with busy=0. After E0: busy=1.
- After edge Ek, for k=1..WIDTH: d_valid=1 and d_bit = difference bit k−1.
- After EWIDTH:
  - busy=0, done=1, d_valid=1 (last bit).
  - diff and bout hold the final values.
- After EWIDTH+1: done=0 and d_valid=0, unless a start accepted at EWIDTH+1 begins a new run.
- Latency from the start-sampling edge to done: WIDTH cycles. Throughput: one operation per WIDTH+1 cycles back-to-back, with start held high.
- busy is high for exactly WIDTH cycles per operation.
- done and d_valid are single-cycle pulses; there is no backpressure.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, bin=0, one-cycle start:
  - d_bit stream is 1,1,1,0,1,1,0,0 (LSB first).
  - done fires 8 cycles after the start edge.
  - diff=0x37, bout=0.
- a=0x00, b=0x01, bin=0: diff=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1: diff=0x00, bout=0.
- a=0x80, b=0x80, bin=1: diff=0xFF, bout=1. Also the corner a=0xFF, b=0x00, bin=0: diff=0xFF, bout=0.
- Start a=0x5A, b=0x23, then pulse start with a=0x01, b=0x01 at cycle 3 of SHIFT:
  - The second start is ignored; result is 0x37.
  - busy is high for exactly 8 cycles, and only one done pulse occurs.
- start held high continuously with operands changing every done:
  - Operations run back-to-back, each with done spaced 9 cycles apart.
  - Each diff matches (a − b − bin) mod 256.
- Assert rstn low at cycle 4 of SHIFT:
  - All outputs go to 0 immediately (async), with no done pulse.
  - After release, a new start with a=0x05, b=0x03 gives diff=0x02, bout=0.
